// File: rtl/uart_pkg.sv
// UART shared definitions: FSM encoding and default line timing.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int CLK_FREQUENCY_MHZ = 27;
  localparam int BAUD_RATE         = 115_200;

  function automatic int cycles_per_bit(
    input int f_mhz,
    input int baud
  );
    return (f_mhz * 1_000_000) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CYCLES-1 and pulses bit_tick on the last
// cycle of each bit; i_restart holds it at zero.
module uart_baud_counter #(
  parameter int CYCLES = 234,
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_restart,
  output logic [CW-1:0] o_count,
  output logic          o_bit_tick
);

  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] count;

  assign o_count    = count;
  assign o_bit_tick = !i_restart && (count == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_restart || o_bit_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter with a one-byte holding register in front of the
// shift register, so the next byte can be queued during a frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int clk_frequency = CLK_FREQUENCY_MHZ,
  parameter int baud_rate     = BAUD_RATE
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data_byte,
  output logic       o_ready,
  output logic       o_data_bit,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CPB = cycles_per_bit(clk_frequency, baud_rate);
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(CPB - 2);

  uart_state_t   state;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_idx;
  logic [7:0]    hold_reg;
  logic          hold_full;
  logic          data_bit;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic          bit_tick;

  uart_baud_counter #(
    .CYCLES (CPB)
  ) u_baud (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_restart  (state == IDLE),
    .o_count    (count),
    .o_bit_tick (bit_tick)
  );

  assign o_ready    = !hold_full;
  assign o_data_bit = data_bit;
  assign o_busy     = busy;
  assign o_done     = done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      data_bit  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // raised one cycle early so the pulse lands on the last stop cycle
      done <= (state == STOP) && (count == PRE_LAST);
      if (i_valid && !hold_full) begin
        hold_reg  <= i_data_byte;
        hold_full <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (hold_full) begin
            shift_reg <= hold_reg;
            hold_full <= 1'b0;
            state     <= START;
            data_bit  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state    <= DATA;
            bit_idx  <= '0;
            data_bit <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              data_bit <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              data_bit  <= shift_reg[1];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (hold_full) begin
              shift_reg <= hold_reg;
              hold_full <= 1'b0;
              state     <= START;
              data_bit  <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: line-level frame monitor with a byte
// scoreboard, plus a small-parameter instance for the timing sweep.
module tb_uart_tx;

  localparam int CPB   = 234;
  localparam int FRAME = 10 * CPB;
  localparam int CPB2  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [7:0] data;
  logic       ready, line, busy, done;
  logic       v2;
  logic [7:0] d2;
  logic       ready2, line2, busy2, done2;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  logic       mon_active = 1'b0;
  logic       mon_err;
  logic       mon_unexp;
  logic [7:0] mon_exp;
  logic       prev_line = 1'b1;
  int         mon_cyc;
  int         mon_start = 0;
  int         mon_end = 0;
  int         mon_gap = 0;
  int         frames = 0;
  int         done_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .i_data_byte (data),
    .o_ready     (ready),
    .o_data_bit  (line),
    .o_busy      (busy),
    .o_done      (done)
  );

  uart_tx #(
    .clk_frequency (1),
    .baud_rate     (300_000)
  ) u_dut2 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (v2),
    .i_data_byte (d2),
    .o_ready     (ready2),
    .o_data_bit  (line2),
    .o_busy      (busy2),
    .o_done      (done2)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Receiver model: checks every cycle of a frame against the expected byte.
  always @(negedge clk) begin
    int  idx;
    logic eb;
    if (!rst_n) begin
      mon_active = 1'b0;
      prev_line  = 1'b1;
    end else begin
      if (!mon_active && prev_line && line === 1'b0) begin
        mon_active = 1'b1;
        mon_cyc    = 0;
        mon_err    = 1'b0;
        mon_gap    = cyc - mon_end;
        mon_start  = cyc;
        mon_unexp  = (exp_q.size() == 0);
        mon_exp    = mon_unexp ? 8'h00 : exp_q.pop_front();
      end
      if (mon_active) begin
        idx = mon_cyc / CPB;
        eb  = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : mon_exp[idx-1];
        if (line !== eb) mon_err = 1'b1;
        if (done !== (mon_cyc == FRAME - 1)) mon_err = 1'b1;
        if (mon_cyc == FRAME - 1) begin
          total++;
          if (mon_err || mon_unexp)
            $display("FAIL frame got_err=%0b unexpected=%0b required_byte=%h",
                     mon_err, mon_unexp, mon_exp);
          else
            passed++;
          frames++;
          mon_active = 1'b0;
          mon_end    = cyc;
        end
        mon_cyc++;
      end
      prev_line = line;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, output int acc);
    int n = 0;
    step();
    valid = 1'b1;
    data  = b;
    while (!ready && n < 4 * FRAME) begin
      step();
      n++;
    end
    if (!ready) begin
      total++;
      $display("FAIL send_timeout byte=%h ready=%b required=1", b, ready);
      valid = 1'b0;
      acc   = -1;
    end else begin
      acc = cyc;
      exp_q.push_back(b);
      step();
      valid = 1'b0;
      data  = 8'($urandom);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((mon_active || exp_q.size() != 0 || busy) && n < 4 * FRAME) begin
      step();
      n++;
    end
    total++;
    if (mon_active || exp_q.size() != 0 || busy)
      $display("FAIL %s_idle got_busy=%b queued=%0d required=idle",
               tag, busy, exp_q.size());
    else
      passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    v2    = 1'b0;
    d2    = 8'h00;
    repeat (3) step();
    total++;
    if (line !== 1'b1) $display("FAIL rst_line got=%b required=1", line);
    else passed++;
    total++;
    if (ready !== 1'b1) $display("FAIL rst_ready got=%b required=1", ready);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL rst_busy got=%b required=0", busy);
    else passed++;
    total++;
    if (done !== 1'b0) $display("FAIL rst_done got=%b required=0", done);
    else passed++;
    rst_n = 1'b1;
    repeat (20) step();
    total++;
    if (busy !== 1'b0 || line !== 1'b1 || frames != 0)
      $display("FAIL rst_no_frame got_busy=%b line=%b required=0,1", busy, line);
    else passed++;
  endtask

  task automatic test_single_byte();
    int acc;
    int d0 = done_cnt;
    int f0 = frames;
    send(8'h5A, acc);
    wait_idle("single");
    total++;
    if (mon_start - acc != 2)
      $display("FAIL latency got=%0d required=2", mon_start - acc);
    else passed++;
    total++;
    if (done_cnt - d0 != 1)
      $display("FAIL single_done got=%0d required=1", done_cnt - d0);
    else passed++;
    total++;
    if (frames - f0 != 1)
      $display("FAIL single_frames got=%0d required=1", frames - f0);
    else passed++;
  endtask

  task automatic test_loopback();
    int acc;
    int f0 = frames;
    send(8'h00, acc);
    send(8'hFF, acc);
    wait_idle("loopback");
    total++;
    if (frames - f0 != 2)
      $display("FAIL loopback_frames got=%0d required=2", frames - f0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int acc;
    int n = 0;
    int d0 = done_cnt;
    step();
    valid = 1'b1;
    data  = 8'h5C;
    acc   = cyc;
    exp_q.push_back(8'h5C);
    step();
    total++;
    if (ready !== 1'b0) $display("FAIL b2b_ready_held got=%b required=0", ready);
    else passed++;
    data = 8'h5D;
    step();
    total++;
    if (ready !== 1'b1) $display("FAIL b2b_ready_loaded got=%b required=1", ready);
    else passed++;
    exp_q.push_back(8'h5D);
    step();
    total++;
    if (ready !== 1'b0) $display("FAIL b2b_ready_second got=%b required=0", ready);
    else passed++;
    valid = 1'b0;
    data  = 8'($urandom);
    while (!ready && n < 2 * FRAME) begin
      step();
      n++;
    end
    total++;
    if (cyc != acc + 2 + FRAME)
      $display("FAIL b2b_ready_rise got=%0d required=%0d", cyc - acc, 2 + FRAME);
    else passed++;
    wait_idle("b2b");
    total++;
    if (mon_gap != 1) $display("FAIL b2b_gap got=%0d required=1", mon_gap);
    else passed++;
    total++;
    if (done_cnt - d0 != 2)
      $display("FAIL b2b_done got=%0d required=2", done_cnt - d0);
    else passed++;
  endtask

  task automatic test_backpressure();
    int acc;
    int f0 = frames;
    send(8'h11, acc);
    send(8'h22, acc);
    total++;
    if (ready !== 1'b0) $display("FAIL bp_full got=%b required=0", ready);
    else passed++;
    valid = 1'b1;
    data  = 8'hEE;
    step();
    valid = 1'b0;
    data  = 8'($urandom);
    total++;
    if (ready !== 1'b0) $display("FAIL bp_still_full got=%b required=0", ready);
    else passed++;
    wait_idle("bp");
    total++;
    if (frames - f0 != 2)
      $display("FAIL bp_frames got=%0d required=2", frames - f0);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int acc;
    int n = 0;
    int d0, f0;
    send(8'hA5, acc);
    send(8'h77, acc);
    while (!(mon_active && mon_cyc >= 4 * CPB + CPB / 2) && n < 2 * FRAME) begin
      step();
      n++;
    end
    total++;
    if (line !== 1'b0) $display("FAIL mid_bit3 got=%b required=0", line);
    else passed++;
    d0 = done_cnt;
    f0 = frames;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (line !== 1'b1) $display("FAIL mid_rst_line got=%b required=1", line);
    else passed++;
    total++;
    if (busy !== 1'b0 || ready !== 1'b1)
      $display("FAIL mid_rst_flags got_busy=%b ready=%b required=0,1", busy, ready);
    else passed++;
    exp_q.delete();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3 * CPB) step();
    total++;
    if (frames != f0 || busy !== 1'b0 || done_cnt != d0)
      $display("FAIL mid_abort got_frames=%0d busy=%b dones=%0d required=0,0,0",
               frames - f0, busy, done_cnt - d0);
    else passed++;
    send(8'h3C, acc);
    wait_idle("mid");
    total++;
    if (frames - f0 != 1)
      $display("FAIL mid_next got=%0d required=1", frames - f0);
    else passed++;
  endtask

  task automatic test_param_sweep();
    logic [7:0] b = 8'hC3;
    logic       eb;
    logic       err = 1'b0;
    int         idx;
    step();
    v2 = 1'b1;
    d2 = b;
    total++;
    if (ready2 !== 1'b1) $display("FAIL sweep_ready got=%b required=1", ready2);
    else passed++;
    step();
    v2 = 1'b0;
    d2 = 8'($urandom);
    step();
    for (int k = 0; k < 10 * CPB2; k++) begin
      idx = k / CPB2;
      eb  = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : b[idx-1];
      if (line2 !== eb || done2 !== (k == 10 * CPB2 - 1)) begin
        if (!err)
          $display("FAIL sweep_bit k=%0d got=%b/%b required=%b/%b",
                   k, line2, done2, eb, k == 10 * CPB2 - 1);
        err = 1'b1;
      end
      step();
    end
    total++;
    if (!err) passed++;
    total++;
    if (busy2 !== 1'b0 || line2 !== 1'b1)
      $display("FAIL sweep_end got_busy=%b line=%b required=0,1", busy2, line2);
    else passed++;
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_loopback();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_param_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
